// File: rtl/mult_sched_pkg.sv
// -----------------------------------------------------------------------------
// mult_sched_pkg
// Shared definitions for the multiplier scheduler:
//   state_t         - scheduler FSM states (IDLE/ISSUE/WAIT/RESP)
//   DEFAULT_LATENCY - default cycles from mul_start to response
//   cntWidth()      - width of the cycle counter able to hold LATENCY
// -----------------------------------------------------------------------------
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_LATENCY = 8;

    // Counter width large enough to represent the value LATENCY itself.
    function automatic int cntWidth(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a winner starts
// one position after the previous grant and wraps around.
// Ports:
//   i_req        in  NREQ  request vector
//   i_lastGrant  in  IDXW  index of the most recent grant
//   o_grant      out NREQ  one-hot grant (all zero when nothing requests)
//   o_grantIdx   out IDXW  index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_lastGrant,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_grantIdx
);

    // Walk the requesters in priority order, starting just after the last
    // grant, and take the first one that is requesting. The offset runs up to
    // NREQ so the previous winner is considered last.
    always_comb begin
        int  cand;
        logic found;
        o_grant    = '0;
        o_grantIdx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(i_lastGrant) + off) % NREQ;
            if (!found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_grantIdx    = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/multiplier_scheduler.sv
// -----------------------------------------------------------------------------
// multiplier_scheduler
// Shares one multiplier among NREQ requesters in round-robin order. Each
// product is returned exactly LATENCY cycles after mul_start, independent of
// when the multiplier raises mul_done, so no operand-dependent timing leaks.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_multiplier      flattened operands, requester i at [i*WIDTH +: WIDTH]
//   req_multiplicand    same packing
//   rsp_valid           one-hot, one-cycle response pulse
//   rsp_product         product accompanying rsp_valid
//   mul_start           one-cycle start pulse to the multiplier
//   mul_multiplier/cand latched operands for the multiplier
//   mul_product/done    multiplier result and completion
//   busy                high whenever the FSM is not IDLE
//   latency_err         sticky: a response went out without a done in window
// -----------------------------------------------------------------------------
module multiplier_scheduler
    import mult_sched_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_multiplier,
    input  logic [NREQ*WIDTH-1:0] req_multiplicand,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_multiplier,
    output logic [WIDTH-1:0]      mul_multiplicand,
    input  logic [2*WIDTH-1:0]    mul_product,
    input  logic                  mul_done,
    output logic                  busy,
    output logic                  latency_err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = cntWidth(LATENCY);

    state_t               r_state;
    logic [IDXW-1:0]      r_lastGrant;
    logic [IDXW-1:0]      r_grantIdx;
    logic [CNTW-1:0]      r_count;
    logic                 r_haveDone;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_mulStart;
    logic [WIDTH-1:0]     r_mulA;
    logic [WIDTH-1:0]     r_mulB;
    logic [NREQ-1:0]      r_rspValid;
    logic [2*WIDTH-1:0]   r_rspProduct;
    logic                 r_latencyErr;

    logic [NREQ-1:0]      w_grant;
    logic [IDXW-1:0]      w_grantIdx;
    logic                 w_handshake;
    logic                 w_lastCount;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arbiter (
        .i_req       (req_valid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant),
        .o_grantIdx  (w_grantIdx)
    );

    // Ready is offered only in IDLE; gating with rst keeps it low while the
    // reset is held, even though the arbiter itself is combinational.
    assign req_ready   = (r_state == IDLE && rst) ? w_grant : '0;
    assign w_handshake = (r_state == IDLE) && (|(req_valid & w_grant));
    assign w_lastCount = (r_count == CNTW'(LATENCY - 1));

    assign mul_start        = r_mulStart;
    assign mul_multiplier   = r_mulA;
    assign mul_multiplicand = r_mulB;
    assign rsp_valid        = r_rspValid;
    assign rsp_product      = r_rspProduct;
    assign latency_err      = r_latencyErr;
    assign busy             = (r_state != IDLE);

    // Scheduler FSM. The response is launched on the same edge that ends the
    // last WAIT cycle, so a done arriving in that final cycle still counts:
    // the product is taken straight from mul_product in that case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_lastGrant  <= IDXW'(NREQ - 1);
            r_grantIdx   <= '0;
            r_count      <= '0;
            r_haveDone   <= 1'b0;
            r_product    <= '0;
            r_mulStart   <= 1'b0;
            r_mulA       <= '0;
            r_mulB       <= '0;
            r_rspValid   <= '0;
            r_rspProduct <= '0;
            r_latencyErr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_mulA      <= req_multiplier[w_grantIdx*WIDTH +: WIDTH];
                        r_mulB      <= req_multiplicand[w_grantIdx*WIDTH +: WIDTH];
                        r_grantIdx  <= w_grantIdx;
                        r_lastGrant <= w_grantIdx;
                        r_haveDone  <= 1'b0;
                        r_mulStart  <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mulStart <= 1'b0;
                    r_count    <= CNTW'(1);
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_count <= r_count + CNTW'(1);
                    if (mul_done && !r_haveDone) begin
                        r_haveDone <= 1'b1;
                        r_product  <= mul_product;
                    end
                    if (w_lastCount) begin
                        r_state    <= RESP;
                        r_rspValid <= NREQ'(1) << r_grantIdx;
                        if (r_haveDone) begin
                            r_rspProduct <= r_product;
                        end else if (mul_done) begin
                            r_rspProduct <= mul_product;
                        end else begin
                            r_rspProduct <= '0;
                            r_latencyErr <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_rspValid   <= '0;
                    r_rspProduct <= '0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_scheduler.sv
// -----------------------------------------------------------------------------
// tb_multiplier_scheduler
// Directed self-checking bench for multiplier_scheduler. The bench plays the
// multiplier: it raises mul_done with a hand-computed product at chosen cycle
// offsets after mul_start.
// -----------------------------------------------------------------------------
module tb_multiplier_scheduler;

    localparam int WIDTH   = 4;
    localparam int NREQ    = 4;
    localparam int LATENCY = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_multiplier;
    logic [NREQ*WIDTH-1:0] req_multiplicand;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_multiplier;
    logic [WIDTH-1:0]      mul_multiplicand;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  mul_done;
    logic                  busy;
    logic                  latency_err;

    int total      = 0;
    int bad        = 0;
    int cycleCount = 0;
    int prevHs     = 0;

    multiplier_scheduler #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplier   (req_multiplier),
        .req_multiplicand (req_multiplicand),
        .rsp_valid        (rsp_valid),
        .rsp_product      (rsp_product),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .busy             (busy),
        .latency_err      (latency_err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure handshake spacing.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the valid vector; the selected requester gets (a,b) and every
    // other requester gets different operands so a wrong mux choice shows.
    task automatic applyStimulus(input logic [3:0] valid, input int idx,
                                 input logic [3:0] a, input logic [3:0] b);
        req_valid = valid;
        for (int i = 0; i < NREQ; i++) begin
            req_multiplier[i*WIDTH +: WIDTH]   = (i == idx) ? a : (a ^ 4'hA);
            req_multiplicand[i*WIDTH +: WIDTH] = (i == idx) ? b : (b ^ 4'h5);
        end
    endtask

    // One full operation from the IDLE cycle of the handshake (A) through the
    // first IDLE cycle after the response (T+LATENCY+1). done1/done2 are cycle
    // offsets from T at which mul_done is raised (0 = never).
    task automatic runOp(input string name, input logic [3:0] valid, input int idx,
                         input logic [3:0] a, input logic [3:0] b,
                         input int done1, input logic [7:0] p1,
                         input int done2, input logic [7:0] p2,
                         input logic [7:0] expProd, input logic expErr,
                         input logic checkSpacing);
        logic [3:0] oneHot;
        int hsCycle;
        oneHot = 4'b0001 << idx;
        applyStimulus(valid, idx, a, b);
        #1;
        hsCycle = cycleCount;
        checkOutput({name, ".ready"}, req_ready, oneHot);
        if (checkSpacing) checkOutput({name, ".spacing"}, hsCycle - prevHs, LATENCY + 2);
        prevHs = hsCycle;
        tick();
        checkOutput({name, ".start"}, mul_start, 1);
        checkOutput({name, ".opA"}, mul_multiplier, a);
        checkOutput({name, ".opB"}, mul_multiplicand, b);
        checkOutput({name, ".busy"}, busy, 1);
        for (int k = 1; k <= LATENCY; k++) begin
            tick();
            if (k == 1) begin
                checkOutput({name, ".startPulse"}, mul_start, 0);
                checkOutput({name, ".readyWait"}, req_ready, 0);
            end
            if (k == LATENCY - 1) checkOutput({name, ".earlyRsp"}, rsp_valid, 0);
            if (k == LATENCY) begin
                checkOutput({name, ".rspValid"}, rsp_valid, oneHot);
                checkOutput({name, ".rspProduct"}, rsp_product, expProd);
                checkOutput({name, ".latErr"}, latency_err, expErr);
            end
            mul_done    = (k == done1) || (k == done2);
            mul_product = (k == done1) ? p1 : ((k == done2) ? p2 : 8'h00);
        end
        tick();
        mul_done    = 1'b0;
        mul_product = 8'h00;
        checkOutput({name, ".rspDrop"}, rsp_valid, 0);
        checkOutput({name, ".idle"}, busy, 0);
    endtask

    initial begin
        rst         = 1'b0;
        mul_done    = 1'b0;
        mul_product = 8'h00;
        applyStimulus(4'b1111, 0, 4'h0, 4'h0);
        tick();
        tick();
        checkOutput("reset.ready", req_ready, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.start", mul_start, 0);
        checkOutput("reset.rspValid", rsp_valid, 0);
        checkOutput("reset.rspProduct", rsp_product, 0);
        checkOutput("reset.latErr", latency_err, 0);
        checkOutput("reset.opA", mul_multiplier, 0);
        rst = 1'b1;

        // Start an operation, then pull reset in the middle of WAIT.
        $display("[TB] reset during WAIT");
        applyStimulus(4'b1111, 0, 4'h3, 4'h4);
        tick();
        tick();
        tick();
        checkOutput("midop.busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("midop.busyAfter", busy, 0);
        checkOutput("midop.ready", req_ready, 0);
        checkOutput("midop.opA", mul_multiplier, 0);
        checkOutput("midop.opB", mul_multiplicand, 0);
        checkOutput("midop.start", mul_start, 0);
        tick();
        tick();
        checkOutput("midop.noRsp", rsp_valid, 0);
        rst = 1'b1;

        // All four valid continuously: 0,1,2,3,0 at LATENCY+2 spacing.
        $display("[TB] round robin with all requesters valid");
        runOp("rr0",  4'b1111, 0, 4'd2,  4'd3,  2, 8'h06, 0, 8'h00, 8'h06, 1'b0, 1'b0);
        runOp("rr1",  4'b1111, 1, 4'd4,  4'd5,  2, 8'h14, 0, 8'h00, 8'h14, 1'b0, 1'b1);
        runOp("rr2",  4'b1111, 2, 4'd6,  4'd7,  2, 8'h2A, 0, 8'h00, 8'h2A, 1'b0, 1'b1);
        runOp("rr3",  4'b1111, 3, 4'd9,  4'd9,  2, 8'h51, 0, 8'h00, 8'h51, 1'b0, 1'b1);
        runOp("rr0b", 4'b1111, 0, 4'd10, 4'd11, 2, 8'h6E, 0, 8'h00, 8'h6E, 1'b0, 1'b1);

        // Fairness: after 2 wins, only 1 and 3 request -> 3 then 1.
        $display("[TB] fairness");
        runOp("fair2", 4'b0100, 2, 4'd1, 4'd2, 3, 8'h02, 0, 8'h00, 8'h02, 1'b0, 1'b0);
        runOp("fair3", 4'b1010, 3, 4'd3, 4'd3, 3, 8'h09, 0, 8'h00, 8'h09, 1'b0, 1'b0);
        runOp("fair1", 4'b1010, 1, 4'd5, 4'd5, 3, 8'h19, 0, 8'h00, 8'h19, 1'b0, 1'b0);

        // Single request, done at T+5; then done in the last accepted cycle.
        $display("[TB] single request and window boundary");
        runOp("single",  4'b0001, 0, 4'd3, 4'd5, 5, 8'h0F, 0, 8'h00, 8'h0F, 1'b0, 1'b0);
        runOp("lastwin", 4'b0100, 2, 4'd4, 4'd4, 7, 8'h10, 0, 8'h00, 8'h10, 1'b0, 1'b0);

        // Only the first of two done pulses is kept.
        $display("[TB] multiple done pulses");
        runOp("multi", 4'b0010, 1, 4'hF, 4'hF, 1, 8'hE1, 3, 8'h00, 8'hE1, 1'b0, 1'b0);

        // No done, then done exactly at T+LATENCY, then a good operation.
        $display("[TB] latency errors");
        runOp("missing", 4'b1000, 3, 4'd8, 4'd8, 0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b0);
        runOp("late",    4'b0001, 0, 4'd2, 4'd2, 8, 8'h04, 0, 8'h00, 8'h00, 1'b1, 1'b0);
        runOp("after",   4'b0100, 2, 4'd7, 4'd6, 4, 8'h2A, 0, 8'h00, 8'h2A, 1'b1, 1'b0);

        req_valid = 4'b0000;
        tick();
        checkOutput("final.ready", req_ready, 0);
        checkOutput("final.busy", busy, 0);
        checkOutput("final.latErr", latency_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
